mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Multi-port memory arbiter: picks one LOAD/STORE per cycle into a registered memory command
// stage and routes load data back to the issuing port after a fixed memory latency.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned RR_MODE   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2*NUM_PORTS-1:0]      req_cmd,
    input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
    input  logic [DATA_W*NUM_PORTS-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_grant,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [1:0]                  mem_cmd,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ready,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int unsigned IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;

    logic [1:0]        cmd_arr   [NUM_PORTS];
    logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0] wdata_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_vld;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign cmd_arr[g]   = req_cmd[2*g +: 2];
        assign addr_arr[g]  = req_addr[ADDR_W*g +: ADDR_W];
        assign wdata_arr[g] = req_wdata[DATA_W*g +: DATA_W];
        // Reserved encoding 11 is never a request.
        assign req_vld[g]   = (cmd_arr[g] == CMD_LOAD) || (cmd_arr[g] == CMD_STORE);
    end

    logic [IDW-1:0] last_grant_q;
    logic [IDW-1:0] win_idx;
    logic           found;
    logic           load_en;
    int             start_idx;
    int             scan_idx;

    logic [IDW-1:0] mem_id_q;
    logic           accept;

    logic           pipe_vld_q [LATENCY];
    logic [IDW-1:0] pipe_id_q  [LATENCY];

    assign load_en = (mem_cmd == CMD_NONE) || mem_ready;

    // Circular scan starting after the previous winner; fixed priority starts at port 0.
    always_comb begin
        found     = 1'b0;
        win_idx   = '0;
        start_idx = 0;
        scan_idx  = 0;
        if (RR_MODE != 0) begin
            start_idx = int'(last_grant_q) + 1;
            if (start_idx >= int'(NUM_PORTS)) begin
                start_idx = 0;
            end
        end
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            scan_idx = start_idx + k;
            if (scan_idx >= int'(NUM_PORTS)) begin
                scan_idx = scan_idx - int'(NUM_PORTS);
            end
            if (!found && req_vld[IDW'(scan_idx)]) begin
                found   = 1'b1;
                win_idx = IDW'(scan_idx);
            end
        end
    end

    always_comb begin
        req_grant = '0;
        if (rst && load_en && found) begin
            req_grant = NUM_PORTS'(1) << win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_cmd      <= CMD_NONE;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_id_q     <= '0;
            last_grant_q <= IDW'(NUM_PORTS - 1);
        end else if (load_en) begin
            if (found) begin
                mem_cmd      <= cmd_arr[win_idx];
                mem_addr     <= addr_arr[win_idx];
                mem_wdata    <= wdata_arr[win_idx];
                mem_id_q     <= win_idx;
                last_grant_q <= win_idx;
            end else begin
                mem_cmd <= CMD_NONE;
            end
        end
    end

    assign accept = (mem_cmd == CMD_LOAD) && mem_ready;

    // Stage LATENCY-1 is valid in exactly the cycle the memory drives the matching read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_id_q[i]  <= '0;
            end
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            pipe_vld_q[0] <= accept;
            pipe_id_q[0]  <= mem_id_q;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
            if (pipe_vld_q[LATENCY-1]) begin
                rsp_valid <= NUM_PORTS'(1) << pipe_id_q[LATENCY-1];
                rsp_data  <= mem_rdata;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin and a fixed-priority instance share
// the same stimulus; expected values are hand-computed per cycle.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_cmd;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [1:0]  rr_grant, rr_rsp_valid, rr_mem_cmd;
    logic [31:0] rr_rsp_data, rr_mem_addr, rr_mem_wdata;
    logic [1:0]  fp_grant, fp_rsp_valid, fp_mem_cmd;
    logic [31:0] fp_rsp_data, fp_mem_addr, fp_mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .LATENCY(2), .RR_MODE(1)
    ) dut_rr (
        .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_grant(rr_grant), .rsp_valid(rr_rsp_valid), .rsp_data(rr_rsp_data),
        .mem_cmd(rr_mem_cmd), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(
        .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .LATENCY(2), .RR_MODE(0)
    ) dut_fp (
        .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_grant(fp_grant), .rsp_valid(fp_rsp_valid), .rsp_data(fp_rsp_data),
        .mem_cmd(fp_mem_cmd), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        req_cmd   = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        // Reset state
        tick();
        check("rst_grant", rr_grant, 2'b00);
        check("rst_mem_cmd", rr_mem_cmd, 2'b00);
        check("rst_mem_addr", rr_mem_addr, 32'h0);
        check("rst_mem_wdata", rr_mem_wdata, 32'h0);
        check("rst_rsp_valid", rr_rsp_valid, 2'b00);
        check("rst_rsp_data", rr_rsp_data, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Single load from port 1
        req_cmd   = 4'b0100;
        req_addr  = {32'h0000_0100, 32'h0};
        mem_ready = 1'b1;
        #1;
        check("single_grant_c0", rr_grant, 2'b10);
        tick();
        req_cmd = 4'b0000;
        #1;
        check("single_mem_cmd_c1", rr_mem_cmd, 2'b01);
        check("single_mem_addr_c1", rr_mem_addr, 32'h100);
        tick();
        check("single_mem_cmd_c2", rr_mem_cmd, 2'b00);
        check("single_rsp_c2", rr_rsp_valid, 2'b00);
        tick();
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("single_rsp_c3", rr_rsp_valid, 2'b00);
        tick();
        mem_rdata = 32'h0;
        check("single_rsp_valid_c4", rr_rsp_valid, 2'b10);
        check("single_rsp_data_c4", rr_rsp_data, 32'hDEAD_BEEF);
        tick();
        check("single_rsp_valid_c5", rr_rsp_valid, 2'b00);
        check("single_rsp_hold_c5", rr_rsp_data, 32'hDEAD_BEEF);

        // Round-robin contention with back-to-back loads
        apply_reset();
        req_addr  = {32'h0000_00B0, 32'h0000_00A0};
        mem_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            req_cmd   = (c < 4) ? 4'b0101 : 4'b0000;
            mem_rdata = 32'h1000 + c;
            #1;
            if (c < 4) begin
                check($sformatf("rr_grant_c%0d", c), rr_grant, (c % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (c >= 1 && c <= 4) begin
                check($sformatf("rr_mem_addr_c%0d", c), rr_mem_addr,
                      ((c - 1) % 2 == 0) ? 32'hA0 : 32'hB0);
            end
            if (c >= 4 && c < 8) begin
                check($sformatf("rr_rsp_valid_c%0d", c), rr_rsp_valid,
                      ((c - 4) % 2 == 0) ? 2'b01 : 2'b10);
                check($sformatf("rr_rsp_data_c%0d", c), rr_rsp_data, 32'h1000 + c - 1);
            end
            if (c == 8) begin
                check("rr_rsp_valid_drained", rr_rsp_valid, 2'b00);
            end
            tick();
        end

        // Fixed priority vs round-robin under the same contention
        req_cmd = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("fp_grant_c%0d", c), fp_grant, 2'b01);
            check($sformatf("rr_alt_grant_c%0d", c), rr_grant, (c % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        req_cmd = 4'b0000;
        for (int c = 0; c < 5; c++) tick();

        // Backpressure on a store
        req_cmd   = 4'b0010;
        req_addr  = {32'h0000_0300, 32'h0000_0020};
        req_wdata = {32'h0, 32'h0000_0055};
        mem_ready = 1'b0;
        #1;
        check("bp_store_grant", rr_grant, 2'b01);
        tick();
        req_cmd = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp_hold_cmd_c%0d", c), rr_mem_cmd, 2'b10);
            check($sformatf("bp_hold_addr_c%0d", c), rr_mem_addr, 32'h20);
            check($sformatf("bp_hold_wdata_c%0d", c), rr_mem_wdata, 32'h55);
            check($sformatf("bp_no_grant_c%0d", c), rr_grant, 2'b00);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("bp_release_grant", rr_grant, 2'b10);
        tick();
        req_cmd = 4'b0000;
        #1;
        check("bp_next_cmd", rr_mem_cmd, 2'b01);
        check("bp_next_addr", rr_mem_addr, 32'h300);
        for (int c = 0; c < 5; c++) tick();

        // Reset while a load is in flight
        req_cmd  = 4'b0001;
        req_addr = {32'h0, 32'h0000_0400};
        tick();
        req_cmd = 4'b0000;
        #1;
        check("rmf_mem_cmd", rr_mem_cmd, 2'b01);
        tick();
        rst = 1'b0;
        #1;
        check("rmf_grant", rr_grant, 2'b00);
        check("rmf_mem_cmd_rst", rr_mem_cmd, 2'b00);
        check("rmf_mem_addr_rst", rr_mem_addr, 32'h0);
        check("rmf_rsp_valid_rst", rr_rsp_valid, 2'b00);
        check("rmf_rsp_data_rst", rr_rsp_data, 32'h0);
        tick();
        rst       = 1'b1;
        mem_rdata = 32'h0000_CAFE;
        tick();
        mem_rdata = 32'h0;
        check("rmf_no_rsp_c4", rr_rsp_valid, 2'b00);
        check("rmf_rsp_data_c4", rr_rsp_data, 32'h0);
        tick();
        check("rmf_no_rsp_c5", rr_rsp_valid, 2'b00);

        // Reserved command is never granted
        req_cmd = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("resv_grant_c%0d", c), rr_grant, 2'b00);
            check($sformatf("resv_mem_cmd_c%0d", c), rr_mem_cmd, 2'b00);
            tick();
        end

        // Store completes on grant and produces no response
        req_cmd   = 4'b1000;
        req_addr  = {32'h0000_0044, 32'h0};
        req_wdata = {32'h0000_0077, 32'h0};
        #1;
        check("st_grant", rr_grant, 2'b10);
        tick();
        req_cmd = 4'b0000;
        #1;
        check("st_mem_cmd", rr_mem_cmd, 2'b10);
        check("st_mem_wdata", rr_mem_wdata, 32'h77);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("st_no_rsp_c%0d", c), rr_rsp_valid, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
